// File: rtl/halloween_prog_writer.sv
// rtl/halloween_prog_writer.sv - one-hot request encoder and atomic 4-slot opcode program writer
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   cmd_valid        request present
//   cmd_onehot       one-hot action request, bit k requests opcode k
//   cmd_ready        request accepted when cmd_valid && cmd_ready (low only in COMMIT)
//   commit           single-cycle strobe to publish the shadow buffer
//   data             published program, slot k at bits [OPW*k +: OPW]
//   prog_valid       a program has been published
//   slot_count       number of shadow slots written (0..SLOTS)
//   err              registered one-cycle error pulse
module halloween_prog_writer #(
    parameter int SLOTS = 4,
    parameter int OPW   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [(1<<OPW)-1:0]   cmd_onehot,
    output logic                  cmd_ready,
    input  logic                  commit,
    output logic [SLOTS*OPW-1:0]  data,
    output logic                  prog_valid,
    output logic [2:0]            slot_count,
    output logic                  err
);
    localparam int NCMD = 1 << OPW;
    localparam int SW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [OPW-1:0] OP_RESET = OPW'(1);

    typedef enum logic [2:0] {EMPTY, FILL, FULL, COMMIT, RUN} state_t;

    state_t               state, state_next;
    logic [OPW-1:0]       shadow [SLOTS];

    logic [OPW:0]         ones;
    logic [OPW-1:0]       idx;
    logic                 legal;
    logic                 accept;

    logic                 wr_en;
    logic [SW-1:0]        wr_slot;
    logic                 shadow_clr;
    logic                 clear_all;
    logic                 publish;
    logic                 err_next;
    logic [2:0]           cnt_next;
    logic [SW-1:0]        last_slot;
    logic [SLOTS*OPW-1:0] pub_data;

    assign cmd_ready = (state != COMMIT);
    assign accept    = cmd_valid && cmd_ready;

    // Encode: index of the single set bit; anything else, or a reserved index, is illegal.
    always_comb begin
        ones = '0;
        idx  = '0;
        for (int i = 0; i < NCMD; i++) begin
            if (cmd_onehot[i]) begin
                ones = ones + {{OPW{1'b0}}, 1'b1};
                idx  = OPW'(i);
            end
        end
        legal = (ones == {{OPW{1'b0}}, 1'b1});
        case (idx)
            4'd2, 4'd3, 4'd7, 4'd11, 4'd15: legal = 1'b0;
            default: ;
        endcase
    end

    // Unfilled slots repeat the last written opcode so the reader never sees stale entries.
    always_comb begin
        last_slot = SW'(slot_count - 3'd1);
        pub_data  = '0;
        for (int k = 0; k < SLOTS; k++) begin
            if (3'(k) < slot_count)
                pub_data[k*OPW +: OPW] = shadow[k];
            else
                pub_data[k*OPW +: OPW] = shadow[last_slot];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_slot    = slot_count[SW-1:0];
        shadow_clr = 1'b0;
        clear_all  = 1'b0;
        publish    = 1'b0;
        err_next   = 1'b0;
        cnt_next   = slot_count;

        if (state == COMMIT) begin
            publish    = 1'b1;
            state_next = RUN;
        end

        if (accept) begin
            if (!legal) begin
                err_next = 1'b1;
            end else if (idx == OP_RESET) begin
                clear_all  = 1'b1;
                cnt_next   = '0;
                state_next = EMPTY;
            end else begin
                case (state)
                    EMPTY, FILL: begin
                        wr_en      = 1'b1;
                        cnt_next   = slot_count + 3'd1;
                        state_next = (cnt_next == 3'(SLOTS)) ? FULL : FILL;
                    end
                    FULL: err_next = 1'b1;
                    RUN: begin
                        shadow_clr = 1'b1;
                        wr_en      = 1'b1;
                        wr_slot    = '0;
                        cnt_next   = 3'd1;
                        state_next = FILL;
                    end
                    default: ;
                endcase
            end
        end

        // Commit sees the state after any same-edge command, so it includes that command.
        if (commit && !clear_all) begin
            case (state_next)
                FILL, FULL: if (state != COMMIT) state_next = COMMIT;
                EMPTY:      err_next = 1'b1;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_all) begin
            for (int k = 0; k < SLOTS; k++) shadow[k] <= '0;
            slot_count <= '0;
            data       <= '0;
            prog_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (shadow_clr)
                for (int k = 0; k < SLOTS; k++) shadow[k] <= '0;
            if (wr_en)
                shadow[wr_slot] <= idx;
            slot_count <= cnt_next;
            err        <= err_next;
            if (publish) begin
                data       <= pub_data;
                prog_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_halloween_prog_writer.sv
// tb/tb_halloween_prog_writer.sv - directed self-checking bench for halloween_prog_writer
module tb_halloween_prog_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic [15:0] cmd_onehot;
    logic        cmd_ready;
    logic        commit;
    logic [15:0] data;
    logic        prog_valid;
    logic [2:0]  slot_count;
    logic        err;

    int total = 0;
    int bad   = 0;

    halloween_prog_writer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_onehot (cmd_onehot),
        .cmd_ready  (cmd_ready),
        .commit     (commit),
        .data       (data),
        .prog_valid (prog_valid),
        .slot_count (slot_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send_raw(input logic [15:0] v, input logic c);
        cmd_valid  = 1'b1;
        cmd_onehot = v;
        commit     = c;
        step();
        cmd_valid  = 1'b0;
        cmd_onehot = '0;
        commit     = 1'b0;
    endtask

    task automatic send(input int b);
        send_raw(16'h1 << b, 1'b0);
    endtask

    task automatic do_commit();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    initial begin
        rst = 1'b0; cmd_valid = 1'b0; cmd_onehot = '0; commit = 1'b0;

        do_reset();
        chk("rst_data", 32'(data), 32'h0000);
        chk("rst_pv", 32'(prog_valid), 0);
        chk("rst_cnt", 32'(slot_count), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_err", 32'(err), 0);

        send(4); send(10); send(14);
        chk("fill_cnt", 32'(slot_count), 3);
        chk("fill_data_untouched", 32'(data), 32'h0000);
        do_commit();
        chk("commit_ready_low", 32'(cmd_ready), 0);
        chk("commit_data_not_yet", 32'(data), 32'h0000);
        step();
        chk("commit_ready_back", 32'(cmd_ready), 1);
        chk("commit_data", 32'(data), 32'hEEA4);
        chk("commit_pv", 32'(prog_valid), 1);
        chk("commit_cnt", 32'(slot_count), 3);

        do_commit();
        chk("run_commit_no_err", 32'(err), 0);
        chk("run_commit_ready", 32'(cmd_ready), 1);

        send(12);
        chk("edit_data_held", 32'(data), 32'hEEA4);
        chk("edit_pv_held", 32'(prog_valid), 1);
        chk("edit_cnt", 32'(slot_count), 1);
        do_commit();
        step();
        chk("edit_data", 32'(data), 32'hCCCC);

        do_reset();
        send(4); send(5); send(6); send(8);
        chk("ovf_cnt", 32'(slot_count), 4);
        chk("ovf_no_err_yet", 32'(err), 0);
        send(9);
        chk("ovf_err", 32'(err), 1);
        step();
        chk("ovf_err_single", 32'(err), 0);
        do_commit();
        step();
        chk("ovf_data", 32'(data), 32'h8654);

        send(4);
        send_raw(16'h0002, 1'b1);
        chk("rstcmd_data", 32'(data), 32'h0000);
        chk("rstcmd_pv", 32'(prog_valid), 0);
        chk("rstcmd_err", 32'(err), 0);
        chk("rstcmd_cnt", 32'(slot_count), 0);
        chk("rstcmd_ready", 32'(cmd_ready), 1);
        do_commit();
        chk("empty_commit_err", 32'(err), 1);
        step();
        chk("empty_commit_err_single", 32'(err), 0);

        do_reset();
        send_raw(16'h0000, 1'b0);
        chk("ill_zero_err", 32'(err), 1);
        step();
        chk("ill_zero_err_clr", 32'(err), 0);
        send_raw(16'h0030, 1'b0);
        chk("ill_multi_err", 32'(err), 1);
        step();
        send(3);
        chk("ill_rsvd_err", 32'(err), 1);
        chk("ill_cnt", 32'(slot_count), 0);
        chk("ill_data", 32'(data), 32'h0000);

        do_reset();
        send(4);
        send_raw(16'h1 << 5, 1'b1);
        chk("same_edge_cnt", 32'(slot_count), 2);
        chk("same_edge_ready", 32'(cmd_ready), 0);
        step();
        chk("same_edge_data", 32'(data), 32'h5554);

        do_reset();
        send(4); send(5); send(6); send(8);
        send_raw(16'h1 << 9, 1'b1);
        chk("ovf_commit_err", 32'(err), 1);
        chk("ovf_commit_ready", 32'(cmd_ready), 0);
        step();
        chk("ovf_commit_data", 32'(data), 32'h8654);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/halloween_prog_writer.md
Name: halloween_prog_writer

Overview:
- Writer end of the 4-slot opcode program bus. The breadboard sequencer consumes this bus: it cycles through the slots and decodes each 4-bit opcode to a one-hot action.
- This block accepts one-hot action requests over a valid/ready handshake and encodes each one to its 4-bit opcode. This is the inverse of the 4-to-16 decoder.
- Encoded opcodes fill a shadow buffer. The whole program is published atomically on commit, so the sequencer never sees a partial program.

Parameters:
- SLOTS, 4, number of program slots (the reader is fixed at 4).
- OPW, 4, opcode width in bits.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- cmd_valid  input  1  request present.
- cmd_onehot  input  16  one-hot action request; bit k requests opcode k.
- cmd_ready  output  1  request accepted on any edge where cmd_valid && cmd_ready.
- commit  input  1  single-cycle strobe to publish the shadow buffer.
- data  output  SLOTS*OPW  published program; slot k occupies bits [4k+3:4k].
- prog_valid  output  1  a program has been published.
- slot_count  output  3  number of shadow slots written (0..4).
- err  output  1  registered one-cycle error pulse.

Behaviour:
- Reset (rst=1 at an edge):
  - state=EMPTY; shadow, data, slot_count, prog_valid, err all 0; cmd_ready=1.
  - rst overrides every other input and aborts any fill or commit in progress.
- Legal opcodes: 0000 ON, 0001 RESET, 0100 GREEN, 0101 PURPLE, 0110 ORANGE, 1000 SCREAMING, 1001 CACKLING, 1010 BOO, 1100 WAVEHANDS, 1101 MOVEJAW, 1110 FOG.
  - Reserved: 0010, 0011, 0111, 1011, 1111.
- Encoding:
  - Index of the single set bit of cmd_onehot.
  - Zero bits set, more than one bit set, or a reserved index gives an illegal request. It is still consumed by the handshake, nothing is written, and err=1 on the following cycle.
- States: EMPTY, FILL, FULL, COMMIT, RUN.
  - cmd_ready=0 only in COMMIT; 1 in every other state.
- Accepted legal non-RESET command:
  - EMPTY/FILL: shadow[slot_count]<=opcode, slot_count+1 at the same edge. Go to FULL when the count reaches 4, else FILL.
  - FULL: overflow. Dropped, err pulse, no state change.
  - RUN: shadow cleared, opcode to slot 0, slot_count=1, go to FILL. data and prog_valid are unchanged; the running program continues.
- Accepted RESET command (bit 1), in any state:
  - shadow, slot_count, data, prog_valid cleared; go to EMPTY. No err.
- commit:
  - FILL/FULL: go to COMMIT. On the next edge, data<=shadow with unfilled slots padded by the last written opcode; prog_valid<=1; slot_count unchanged; go to RUN.
  - Latency: commit sampled at edge N, data visible after edge N+1.
  - EMPTY: err pulse, no state change.
  - RUN: ignored, no err.
  - COMMIT: ignored.
- Same-edge events:
  - Command and commit on the same edge: the command is applied first, and the commit includes it.
  - RESET command plus commit: RESET wins and the commit is discarded.
  - FULL overflow plus commit: the command is dropped with err, and the commit proceeds.
- data changes only on the COMMIT-to-RUN edge or on a RESET command/rst. It is never modified during fill.
- ON (0000) is legal in any slot. Publishing slot 0 = 0000 drives the reader's NOR hold and keeps the sequencer in reset; this is intended behaviour.
- err is never asserted for two consecutive cycles from one event.

Test Plan:
- Reset then idle: rst high 2 cycles -> data=16'h0000, prog_valid=0, slot_count=0, cmd_ready=1, err=0.
- Fill and commit: send one-hot bits 4, 10, 14 (GREEN, BOO, FOG), then commit -> slot_count=3; cmd_ready=0 for exactly one cycle; data=16'hEEA4 and prog_valid=1 one cycle after the commit edge.
- Overflow: send bits 4, 5, 6, 8, then bit 9 -> fifth request gives err=1 for one cycle; after commit, data=16'h8654.
- Illegal requests: send cmd_onehot=16'h0000, 16'h0030, then bit 3 (reserved) -> three err pulses; slot_count stays 0; data=16'h0000.
- Edit while running: after data=16'hEEA4, send bit 12 (WAVEHANDS) -> data stays 16'hEEA4 with prog_valid=1; commit -> data=16'hCCCC.
- RESET priority: in FILL, assert the bit-1 request together with commit -> data=16'h0000, prog_valid=0, state EMPTY, no err; a following commit alone -> err pulse.
